seven_seg_scanner: RTL

- Time-multiplexed scan controller for an NUM_DIGITS-wide common-cathode 7-segment module.
- Holds a frame of BCD digits and presents one digit at a time to a single downstream BCD-to-7-segment decoder, driving the matching digit-enable line.
- Provides per-digit decimal points, leading-zero blanking, anti-ghosting blank slots, and tear-free frame updates.
- Sits between the counter/datapath logic producing BCD values and the combinational decoder.

---
 rtl/seven_seg_scanner.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed scan controller for a
// NUM_DIGITS-wide common-cathode 7-segment display.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   en                  scan enable (0 forces IDLE)
//   load                strobe capturing bcd_in/dp_in into the shadow frame
//   bcd_in, dp_in       digit values (digit 0 = bits [3:0]) and decimal points
//   blank_lz            leading-zero blanking enable
//   bcd_out, dp_out     BCD code and decimal point of the selected digit
//   digit_en            one-hot digit enable, active-high
//   digit_idx           index of the selected digit
//   frame_tick          one-cycle pulse on the last cycle of each scan
module seven_seg_scanner #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          load,
   input  logic [4*NUM_DIGITS-1:0]       bcd_in,
   input  logic [NUM_DIGITS-1:0]         dp_in,
   input  logic                          blank_lz,
   output logic [3:0]                    bcd_out,
   output logic                          dp_out,
   output logic [NUM_DIGITS-1:0]         digit_en,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_tick
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam int CW = $clog2(REFRESH_DIV);

   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] SHOW_LAST  =
      CW'(REFRESH_DIV - BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   state_t state, state_n;

   logic [CW-1:0]           cnt, cnt_n;
   logic [IW-1:0]           idx_n;
   logic                    boundary;

   logic [4*NUM_DIGITS-1:0] shadow_bcd, active_bcd, act_bcd_n;
   logic [NUM_DIGITS-1:0]   shadow_dp, active_dp, act_dp_n;
   logic                    pending;

   logic [NUM_DIGITS-1:0]   live;
   logic                    suppress;
   logic [NUM_DIGITS-1:0]   en_d;
   logic [3:0]              bcd_d;
   logic                    dp_d;
   logic                    tick_d;

   // Next state, slot counter and digit index.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      idx_n    = digit_idx;
      boundary = 1'b0;
      if (!en) begin
         state_n = IDLE;
         cnt_n   = '0;
         idx_n   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_n  = BLANK;
               cnt_n    = '0;
               idx_n    = '0;
               boundary = 1'b1;
            end
            BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state_n = SHOW;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            SHOW: begin
               if (cnt == SHOW_LAST) begin
                  state_n = BLANK;
                  cnt_n   = '0;
                  if (digit_idx == IDX_LAST) begin
                     idx_n    = '0;
                     boundary = 1'b1;
                  end else begin
                     idx_n = digit_idx + 1'b1;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
               idx_n   = '0;
            end
         endcase
      end
   end

   // Frame contents seen from the next cycle on; a load on the
   // boundary cycle bypasses the shadow so it shows immediately.
   always_comb begin
      act_bcd_n = active_bcd;
      act_dp_n  = active_dp;
      if (boundary) begin
         if (load) begin
            act_bcd_n = bcd_in;
            act_dp_n  = dp_in;
         end else if (pending) begin
            act_bcd_n = shadow_bcd;
            act_dp_n  = shadow_dp;
         end
      end
   end

   // live[i]: some digit at or above i is nonzero or carries a dp.
   always_comb begin
      logic acc;
      acc  = 1'b0;
      live = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         acc     = acc | (act_bcd_n[4*i +: 4] != 4'd0) | act_dp_n[i];
         live[i] = acc;
      end
   end

   // Output values for the next cycle, derived from next state.
   always_comb begin
      en_d     = '0;
      suppress = blank_lz && (idx_n != '0) && !live[idx_n];
      bcd_d    = act_bcd_n[{idx_n, 2'b00} +: 4];
      dp_d     = act_dp_n[idx_n] && !suppress;
      tick_d   = (state_n == SHOW) && (idx_n == IDX_LAST) &&
                 (cnt_n == SHOW_LAST);
      if (state_n == SHOW && !suppress) begin
         en_d[idx_n] = 1'b1;
      end
      if (state_n == IDLE) begin
         bcd_d = 4'd0;
         dp_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         digit_idx  <= '0;
         shadow_bcd <= '0;
         shadow_dp  <= '0;
         active_bcd <= '0;
         active_dp  <= '0;
         pending    <= 1'b0;
         bcd_out    <= '0;
         dp_out     <= 1'b0;
         digit_en   <= '0;
         frame_tick <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         digit_idx  <= idx_n;
         active_bcd <= act_bcd_n;
         active_dp  <= act_dp_n;
         if (load) begin
            shadow_bcd <= bcd_in;
            shadow_dp  <= dp_in;
         end
         if (boundary) begin
            pending <= 1'b0;
         end else if (load) begin
            pending <= 1'b1;
         end
         bcd_out    <= bcd_d;
         dp_out     <= dp_d;
         digit_en   <= en_d;
         frame_tick <= tick_d;
      end
   end

endmodule
